// File: rtl/crc_check.sv
// Receive-side CRC checker: strips the trailing CRC field through a delay line,
// folds the payload into a running CRC and reports match/mismatch once per frame.
//
// state | meaning
// IDLE  | no word of the current frame accepted yet
// FILL  | delay line partly filled; nothing folded into the CRC yet
// RUN   | delay line full; each accepted beat folds the oldest word into the CRC
module crc_check #(
    parameter logic [63:0] POLY          = 64'h1021,
    parameter int          CRC_SIZE      = 16,
    parameter int          DATA_WIDTH    = 8,
    parameter logic [63:0] INIT          = 64'hffff,
    parameter bit          REF_IN        = 1'b1,
    parameter bit          REF_OUT       = 1'b1,
    parameter logic [63:0] XOR_OUT       = 64'h0000,
    parameter bit          CRC_LSB_FIRST = REF_OUT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  soft_reset_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    output logic                  done_o,
    output logic                  crc_ok_o,
    output logic                  crc_err_o,
    output logic                  short_o,
    output logic [CRC_SIZE-1:0]   calc_crc_o,
    output logic [CRC_SIZE-1:0]   rx_crc_o
);

    localparam int CRC_WORDS = CRC_SIZE / DATA_WIDTH;
    localparam int CNT_W     = $clog2(CRC_WORDS + 1);

    localparam logic [CRC_SIZE-1:0] POLY_C    = POLY[CRC_SIZE-1:0];
    localparam logic [CRC_SIZE-1:0] INIT_C    = INIT[CRC_SIZE-1:0];
    localparam logic [CRC_SIZE-1:0] XOR_C     = XOR_OUT[CRC_SIZE-1:0];
    localparam logic [CNT_W-1:0]    CW_CNT    = CNT_W'(CRC_WORDS);
    localparam logic [CNT_W-1:0]    SHORT_LIM = CNT_W'(CRC_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] reflect_word(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH; i++) r[i] = w[DATA_WIDTH-1-i];
        return r;
    endfunction

    function automatic logic [CRC_SIZE-1:0] reflect_crc(input logic [CRC_SIZE-1:0] c);
        logic [CRC_SIZE-1:0] r;
        for (int i = 0; i < CRC_SIZE; i++) r[i] = c[CRC_SIZE-1-i];
        return r;
    endfunction

    // One DATA_WIDTH-bit parallel step, MSB of the (optionally reflected) word first.
    function automatic logic [CRC_SIZE-1:0] crc_step(input logic [CRC_SIZE-1:0] c_in,
                                                     input logic [DATA_WIDTH-1:0] w);
        logic [CRC_SIZE-1:0]   c;
        logic [DATA_WIDTH-1:0] d;
        logic                  fb;
        c = c_in;
        d = REF_IN ? reflect_word(w) : w;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb = c[CRC_SIZE-1] ^ d[i];
            c  = c << 1;
            if (fb) c = c ^ POLY_C;
        end
        return c;
    endfunction

    state_t                state;
    logic [CNT_W-1:0]      count;
    logic [CRC_SIZE-1:0]   crc;
    logic [DATA_WIDTH-1:0] dline       [CRC_WORDS];
    logic [DATA_WIDTH-1:0] dline_shift [CRC_WORDS];

    logic [CRC_SIZE-1:0] crc_next;
    logic [CRC_SIZE-1:0] crc_final;
    logic [CRC_SIZE-1:0] rx_asm;
    logic [CNT_W-1:0]    count_inc;
    logic                short_now;
    logic                beat;
    logic                last_beat;

    logic                cap_valid;
    logic                cap_short;
    logic [CRC_SIZE-1:0] cap_calc;
    logic [CRC_SIZE-1:0] cap_rx;

    assign beat      = valid_i & ~soft_reset_i;
    assign last_beat = beat & last_i;

    always_comb begin
        for (int i = 0; i < CRC_WORDS - 1; i++) dline_shift[i] = dline[i+1];
        dline_shift[CRC_WORDS-1] = data_i;

        crc_next  = (state == RUN) ? crc_step(crc, dline[0]) : crc;
        crc_final = (REF_OUT ? reflect_crc(crc_next) : crc_next) ^ XOR_C;

        // dline_shift[0] is the first CRC word of the frame; short frames leave zeros in front.
        rx_asm = '0;
        for (int j = 0; j < CRC_WORDS; j++) begin
            if (CRC_LSB_FIRST) rx_asm[j*DATA_WIDTH +: DATA_WIDTH] = dline_shift[j];
            else rx_asm[(CRC_WORDS-1-j)*DATA_WIDTH +: DATA_WIDTH] = dline_shift[j];
        end

        count_inc = count + CNT_W'(1);
        short_now = (count < SHORT_LIM);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || soft_reset_i) begin
            state <= IDLE;
            count <= '0;
            crc   <= INIT_C;
            for (int i = 0; i < CRC_WORDS; i++) dline[i] <= '0;
        end else if (valid_i) begin
            if (last_i) begin
                state <= IDLE;
                count <= '0;
                crc   <= INIT_C;
                for (int i = 0; i < CRC_WORDS; i++) dline[i] <= '0;
            end else begin
                for (int i = 0; i < CRC_WORDS; i++) dline[i] <= dline_shift[i];
                crc <= crc_next;
                if (state != RUN) begin
                    count <= count_inc;
                    state <= (count_inc == CW_CNT) ? RUN : FILL;
                end
            end
        end
    end

    // Capture stage, independent of the input path so back-to-back frames never stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_valid <= 1'b0;
            cap_short <= 1'b0;
            cap_calc  <= '0;
            cap_rx    <= '0;
        end else begin
            cap_valid <= last_beat;
            if (last_beat) begin
                cap_calc  <= crc_final;
                cap_rx    <= rx_asm;
                cap_short <= short_now;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_o     <= 1'b0;
            crc_ok_o   <= 1'b0;
            crc_err_o  <= 1'b0;
            short_o    <= 1'b0;
            calc_crc_o <= '0;
            rx_crc_o   <= '0;
        end else begin
            done_o    <= cap_valid;
            crc_ok_o  <= cap_valid & ~cap_short & (cap_calc == cap_rx);
            crc_err_o <= cap_valid & (cap_short | (cap_calc != cap_rx));
            short_o   <= cap_valid & cap_short;
            if (cap_valid) begin
                calc_crc_o <= cap_calc;
                rx_crc_o   <= cap_rx;
            end
        end
    end

endmodule

// File: tb/tb_crc_check.sv
// Bench for crc_check (CRC-16/MCRF4XX defaults): directed frames plus random frames
// compared against a bytewise reflected CRC model and a frame-level result queue.
module tb_crc_check;

    typedef struct {
        logic        ok;
        logic        err;
        logic        shrt;
        logic [15:0] calc;
        logic [15:0] rx;
        int          cyc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        soft_reset;
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic        done;
    logic        crc_ok;
    logic        crc_err;
    logic        shrt;
    logic [15:0] calc_crc;
    logic [15:0] rx_crc;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    res_t exp_q[$];
    res_t obs_q[$];
    res_t last_obs;
    logic [7:0] frame_q[$];
    logic [7:0] base_frame[11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                                   8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};

    crc_check dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .soft_reset_i (soft_reset),
        .valid_i      (valid),
        .data_i       (data),
        .last_i       (last),
        .done_o       (done),
        .crc_ok_o     (crc_ok),
        .crc_err_o    (crc_err),
        .short_o      (shrt),
        .calc_crc_o   (calc_crc),
        .rx_crc_o     (rx_crc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            res_t o;
            o.ok   = crc_ok;
            o.err  = crc_err;
            o.shrt = shrt;
            o.calc = calc_crc;
            o.rx   = rx_crc;
            o.cyc  = cyc;
            obs_q.push_back(o);
        end
    end

    // Reflected (LSB-first) form of CRC-16/MCRF4XX over frame_q[0 .. n-1].
    function automatic logic [15:0] model_crc(int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, frame_q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c ^ 16'h0000;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic load_base();
        frame_q.delete();
        foreach (base_frame[i]) frame_q.push_back(base_frame[i]);
    endtask

    task automatic idle_cycle();
        valid = 1'b0;
        data  = 8'($urandom);
        last  = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(int gap_pct, bit with_last, bit expect_result);
        int n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) while ($urandom_range(99) < gap_pct) idle_cycle();
            valid = 1'b1;
            data  = frame_q[i];
            last  = with_last && (i == n - 1);
            if (last && expect_result) begin
                res_t e;
                e.shrt = (n < 2);
                e.rx   = (n >= 2) ? {frame_q[n-1], frame_q[n-2]} : 16'h0000;
                e.calc = (n >= 2) ? model_crc(n - 2) : 16'h0000;
                e.ok   = !e.shrt && (e.calc == e.rx);
                e.err  = !e.ok;
                e.cyc  = cyc + 2;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic check_results(string tag);
        int wait_n = 0;
        while (obs_q.size() < exp_q.size() && wait_n < 300) begin
            @(posedge clk);
            #1;
            wait_n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_done_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            res_t e = exp_q.pop_front();
            res_t o = obs_q.pop_front();
            chk({tag, "_ok"}, 32'(o.ok), 32'(e.ok));
            chk({tag, "_err"}, 32'(o.err), 32'(e.err));
            chk({tag, "_short"}, 32'(o.shrt), 32'(e.shrt));
            chk({tag, "_latency"}, o.cyc, e.cyc);
            if (!e.shrt) begin
                chk({tag, "_calc"}, 32'(o.calc), 32'(e.calc));
                chk({tag, "_rx"}, 32'(o.rx), 32'(e.rx));
            end
            last_obs = o;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_ok"}, 32'(crc_ok), 0);
        chk({tag, "_err"}, 32'(crc_err), 0);
        chk({tag, "_short"}, 32'(shrt), 0);
        chk({tag, "_calc"}, 32'(calc_crc), 0);
        chk({tag, "_rx"}, 32'(rx_crc), 0);
    endtask

    initial begin
        rst        = 1'b1;
        soft_reset = 1'b0;
        valid      = 1'b0;
        data       = 8'h00;
        last       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all_zero("reset");

        // check-value frame
        load_base();
        send_frame(0, 1'b1, 1'b1);
        check_results("s1");
        chk("s1_calc_6f91", 32'(last_obs.calc), 32'h6F91);
        chk("s1_ok_direct", 32'(last_obs.ok), 1);

        // corrupted payload byte
        load_base();
        frame_q[4] = 8'h34;
        send_frame(0, 1'b1, 1'b1);
        check_results("s2");
        chk("s2_rx_6f91", 32'(last_obs.rx), 32'h6F91);
        chk("s2_err_direct", 32'(last_obs.err), 1);

        // back-to-back frames with gaps inside
        load_base();
        send_frame(30, 1'b1, 1'b1);
        send_frame(30, 1'b1, 1'b1);
        check_results("s3");

        // short and empty-payload frames, back to back
        frame_q.delete();
        frame_q.push_back(8'hAA);
        send_frame(0, 1'b1, 1'b1);
        send_frame(0, 1'b1, 1'b1);
        frame_q.delete();
        frame_q.push_back(8'hFF);
        frame_q.push_back(8'hFF);
        send_frame(0, 1'b1, 1'b1);
        check_results("s4");
        chk("s4_empty_ok", 32'(last_obs.ok), 1);

        // soft reset mid-frame, concurrent beat with last must be discarded
        load_base();
        for (int i = 0; i < 6; i++) void'(frame_q.pop_back());
        send_frame(0, 1'b0, 1'b0);
        soft_reset = 1'b1;
        valid      = 1'b1;
        data       = 8'($urandom);
        last       = 1'b1;
        @(posedge clk);
        #1;
        soft_reset = 1'b0;
        valid      = 1'b0;
        last       = 1'b0;
        load_base();
        send_frame(0, 1'b1, 1'b1);
        check_results("s5_soft");

        // hard reset one cycle after a last beat kills the pending result
        load_base();
        send_frame(0, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("s5_rst_no_done", obs_q.size(), 0);
        chk_all_zero("s5_rst");
        obs_q.delete();
        load_base();
        send_frame(0, 1'b1, 1'b1);
        check_results("s5_recover");

        // random frames with appended CRC, half of them corrupted
        for (int f = 0; f < 40; f++) begin
            int          np = $urandom_range(62, 0);
            logic [15:0] c;
            frame_q.delete();
            for (int i = 0; i < np; i++) frame_q.push_back(8'($urandom));
            c = model_crc(np);
            frame_q.push_back(c[7:0]);
            frame_q.push_back(c[15:8]);
            if ($urandom_range(1) == 1) begin
                int         k = $urandom_range(frame_q.size() - 1);
                logic [7:0] t = frame_q[k];
                t[$urandom_range(7)] ^= 1'b1;
                frame_q[k] = t;
            end
            send_frame(20, 1'b1, 1'b1);
        end
        check_results("s6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
